// File: rtl/disk_ii_pkg.sv
// Disk II controller shared definitions: track geometry, $C0nX soft-switch
// offsets, motor state encoding and the track-buffer position helper.
package disk_ii_pkg;

  localparam int TRACK_BYTES   = 6656;
  localparam int NUM_TRACKS    = 35;
  localparam int MAX_HALFTRACK = 68;

  // Soft-switch offsets (low nibble of $C0nX)
  localparam logic [3:0] SW_MOTOR_OFF = 4'h8;
  localparam logic [3:0] SW_MOTOR_ON  = 4'h9;
  localparam logic [3:0] SW_DRIVE1    = 4'hA;
  localparam logic [3:0] SW_DRIVE2    = 4'hB;
  localparam logic [3:0] SW_Q6L       = 4'hC;
  localparam logic [3:0] SW_Q6H       = 4'hD;
  localparam logic [3:0] SW_Q7L       = 4'hE;
  localparam logic [3:0] SW_Q7H       = 4'hF;

  typedef enum logic [1:0] {
    MOTOR_OFF_ST      = 2'd0,
    MOTOR_ON_ST       = 2'd1,
    MOTOR_SPINDOWN_ST = 2'd2
  } motor_state_e;

  // Next byte position around the circular track buffer
  function automatic logic [12:0] next_pos(input logic [12:0] p);
    return (p == 13'(TRACK_BYTES - 1)) ? 13'd0 : p + 13'd1;
  endfunction

endpackage

// File: rtl/disk_ii_stepper.sv
// Disk II head stepper: tracks the half-track position from phase-on events
// and saturates at the innermost and outermost half-tracks.
module disk_ii_stepper
  import disk_ii_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       phase_on,
  input  logic [1:0] phase_k,
  output logic [6:0] ht,
  output logic [5:0] track
);

  logic [1:0] fwd_k;
  logic [1:0] back_k;

  assign fwd_k  = ht[1:0] + 2'd1;
  assign back_k = ht[1:0] + 2'd3;
  assign track  = ht[6:1];

  // Step one half-track toward the energised magnet, clamped to 0..68
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ht <= 7'd0;
    end else if (phase_on) begin
      if (phase_k == fwd_k) begin
        if (ht != 7'(MAX_HALFTRACK)) ht <= ht + 7'd1;
      end else if (phase_k == back_k) begin
        if (ht != 7'd0) ht <= ht - 7'd1;
      end
    end
  end

endmodule

// File: rtl/disk_ii_ctrl.sv
// Disk II controller-card sequencer: soft-switch decode, motor control,
// byte-rate track streaming into the read latch and the 6502 read mux.
// Optional motor run-on after MOTOR_OFF is enabled by DISK_II_SPINDOWN_EN.
module disk_ii_ctrl
  import disk_ii_pkg::*;
#(
  parameter int BYTE_CYCLES     = 458,
  parameter int SPINDOWN_CYCLES = 14318180
) (
  input  logic        CLK_14M,
  input  logic        RESET_N,
  input  logic        io_strobe,
  input  logic [3:0]  io_addr,
  output logic [7:0]  d_out,
  input  logic        write_protect,
  output logic [5:0]  track,
  output logic [12:0] trk_addr,
  input  logic [7:0]  trk_data,
  output logic        motor_on,
  output logic        drive_sel
);

  localparam logic [1:0] ST_OFF = MOTOR_OFF_ST;
  localparam logic [1:0] ST_ON  = MOTOR_ON_ST;
  localparam int BC_W = (BYTE_CYCLES > 2) ? $clog2(BYTE_CYCLES) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BYTE_CYCLES - 1);

`ifdef DISK_II_SPINDOWN_EN
  localparam logic [1:0] ST_SPIN = MOTOR_SPINDOWN_ST;
  localparam int SPIN_W = (SPINDOWN_CYCLES > 2) ? $clog2(SPINDOWN_CYCLES) : 1;
  localparam logic [SPIN_W-1:0] SPIN_LOAD = SPIN_W'(SPINDOWN_CYCLES - 1);
  logic [SPIN_W-1:0] spin_cnt;
`endif

  logic [1:0]      state;
  logic [BC_W-1:0] byte_cnt;
  logic [12:0]     pos;
  logic            vld_p1;
  logic [7:0]      latch;
  logic            q6;
  logic            q7;
  logic            motor_on_req;
  logic            motor_off_req;
  logic            phase_on;
  logic            rd_latch;
  logic [6:0]      ht_unused;

  assign motor_on_req  = io_strobe && (io_addr == SW_MOTOR_ON);
  assign motor_off_req = io_strobe && (io_addr == SW_MOTOR_OFF);
  assign phase_on      = io_strobe && !io_addr[3] && io_addr[0];
  assign rd_latch      = io_strobe && !q7 && !q6;
  assign motor_on      = (state != ST_OFF);

  disk_ii_stepper u_stepper (
    .clk      (CLK_14M),
    .rst_n    (RESET_N),
    .phase_on (phase_on),
    .phase_k  (io_addr[2:1]),
    .ht       (ht_unused),
    .track    (track)
  );

  // Motor FSM: MOTOR_ON always wins; MOTOR_OFF only acts from ON
  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_OFF;
`ifdef DISK_II_SPINDOWN_EN
      spin_cnt <= '0;
`endif
    end else if (motor_on_req) begin
      state <= ST_ON;
    end else begin
      case (state)
        ST_ON: begin
          if (motor_off_req) begin
`ifdef DISK_II_SPINDOWN_EN
            state    <= ST_SPIN;
            spin_cnt <= SPIN_LOAD;
`else
            state    <= ST_OFF;
`endif
          end
        end
`ifdef DISK_II_SPINDOWN_EN
        ST_SPIN: begin
          if (spin_cnt == '0) state <= ST_OFF;
          else                spin_cnt <= spin_cnt - 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // Byte-rate sequencer; counter and position freeze while the spindle is stopped
  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      byte_cnt <= '0;
      pos      <= 13'd0;
      trk_addr <= 13'd0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (motor_on) begin
        if (byte_cnt == BC_LAST) begin
          byte_cnt <= '0;
          trk_addr <= pos;
          pos      <= next_pos(pos);
          vld_p1   <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

  // --- stage p1: fetched byte arrives; a fresh byte beats a clearing read ---
  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      latch <= 8'd0;
    end else if (vld_p1) begin
      latch <= trk_data;
    end else if (rd_latch) begin
      latch <= 8'd0;
    end
  end

  // Soft-switch side effects for drive select and the Q6/Q7 mode bits
  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      drive_sel <= 1'b0;
      q6        <= 1'b0;
      q7        <= 1'b0;
    end else if (io_strobe) begin
      case (io_addr)
        SW_DRIVE1: drive_sel <= 1'b0;
        SW_DRIVE2: drive_sel <= 1'b1;
        SW_Q6L:    q6 <= 1'b0;
        SW_Q6H:    q6 <= 1'b1;
        SW_Q7L:    q7 <= 1'b0;
        SW_Q7H:    q7 <= 1'b1;
        default: ;
      endcase
    end
  end

  // Read mux registered per access, using the Q mode in force before it
  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      d_out <= 8'd0;
    end else if (io_strobe) begin
      if (q7)      d_out <= 8'd0;
      else if (q6) d_out <= {write_protect, 7'd0};
      else         d_out <= latch;
    end
  end

endmodule

// File: tb/tb_disk_ii_ctrl.sv
// Directed, scoreboarded bench for disk_ii_ctrl with a short byte period.
module tb_disk_ii_ctrl;

  localparam int BC = 4;
  localparam int SC = 100;
  localparam int NB = 6656;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_strobe = 1'b0;
  logic [3:0]  io_addr = 4'd0;
  logic        wp = 1'b0;
  logic [7:0]  d_out;
  logic [7:0]  trk_data;
  logic [5:0]  track;
  logic [12:0] trk_addr;
  logic        motor_on;
  logic        drive_sel;

  logic [7:0]  mem [0:NB-1];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  assign trk_data = mem[trk_addr];

  disk_ii_ctrl #(.BYTE_CYCLES(BC), .SPINDOWN_CYCLES(SC)) dut (
    .CLK_14M       (clk),
    .RESET_N       (rst_n),
    .io_strobe     (io_strobe),
    .io_addr       (io_addr),
    .d_out         (d_out),
    .write_protect (wp),
    .track         (track),
    .trk_addr      (trk_addr),
    .trk_data      (trk_data),
    .motor_on      (motor_on),
    .drive_sel     (drive_sel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One $C0nX access starting at a falling edge; d_out checked one edge later
  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] e;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    io_addr   = a;
    io_strobe = 1'b1;
    @(negedge clk);
    io_strobe = 1'b0;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, 32'(d_out), 32'(e));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [3:0]  st_addr [9] = '{4'h3, 4'h5, 4'h7, 4'h1, 4'h3, 4'h6, 4'h7, 4'h1, 4'h7};
  int          st_trk  [9] = '{0, 1, 1, 2, 2, 2, 2, 2, 1};

  initial begin
    logic [12:0] prev;
    logic [12:0] expn;
    logic [12:0] held;
    logic [12:0] resume;
    bit          done;
    bit          ok;
    bit          moved;
    int          n;
    int          h;
    int          k;

    for (int i = 0; i < NB; i++) mem[i] = 8'((i * 37 + 11) ^ (i >> 8));
    mem[0] = 8'hD5;
    mem[1] = 8'hAA;

    // reset state
    cyc(3);
    chk("rst_track", 32'(track), 32'd0);
    chk("rst_motor_on", 32'(motor_on), 32'd0);
    chk("rst_d_out", 32'(d_out), 32'd0);
    chk("rst_trk_addr", 32'(trk_addr), 32'd0);
    chk("rst_drive_sel", 32'(drive_sel), 32'd0);
    rst_n = 1'b1;
    rd(4'hC, 8'h00, "q6l_after_reset");

    // first bytes after MOTOR_ON
    rd(4'h9, 8'h00, "motor_on_rd");
    chk("motor_on_set", 32'(motor_on), 32'd1);
    cyc(BC + 1);
    rd(4'hC, 8'hD5, "first_byte");
    rd(4'hC, 8'h00, "reread_cleared");
    cyc(BC - 2);
    rd(4'hC, 8'hAA, "second_byte");
    cyc(2 * BC - 2);
    rd(4'hC, mem[2], "same_cycle_old");
    rd(4'hC, mem[3], "same_cycle_new");
    chk("trk_addr_after_4", 32'(trk_addr), 32'd3);

    // stream around the track end
    prev = 13'd3;
    expn = 13'd4;
    done = 1'b0;
    for (int i = 0; i < 30000 && !done; i++) begin
      @(negedge clk);
      if (trk_addr !== prev) begin
        chk("fetch_addr", 32'(trk_addr), 32'(expn));
        if (prev == 13'(NB - 1)) done = 1'b1;
        prev = trk_addr;
        expn = (expn == 13'(NB - 1)) ? 13'd0 : expn + 13'd1;
      end
    end
    if (!done) chk("wrap_reached", 32'd0, 32'd1);
    rd(4'hC, mem[NB-1], "wrap_same_cycle");
    rd(4'hC, 8'hD5, "wrap_first_byte");

    // Q6/Q7 modes with write protect set
    wp = 1'b1;
    rd(4'hD, 8'h00, "q6h_reads_latch");
    rd(4'hE, 8'h80, "wp_sense");
    rd(4'hF, 8'h80, "q7h_old_mode");
    rd(4'hC, 8'h00, "q7_write_mode");
    rd(4'h0, 8'h00, "q7_write_mode_2");
    rd(4'hE, 8'h00, "q7l_old_mode");
    rd(4'hC, 8'hAA, "latch_after_q7");
    rd(4'hD, mem[2], "latch_before_q6h");

    // motor stop
`ifdef DISK_II_SPINDOWN_EN
    rd(4'h8, 8'h80, "motor_off_rd");
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (!motor_on) break;
      n++;
      @(negedge clk);
    end
    chk("spindown_len", 32'(n), 32'(SC));
    rd(4'h9, 8'h80, "motor_on_rd2");
    rd(4'h8, 8'h80, "motor_off_rd2");
    ok = motor_on;
    for (int i = 0; i < 150; i++) begin
      if (i == 50) rd(4'h9, 8'h80, "cancel_rd");
      else         @(negedge clk);
      if (!motor_on) ok = 1'b0;
    end
    chk("spindown_cancel", 32'(ok), 32'd1);
    rd(4'h8, 8'h80, "motor_off_rd3");
    cyc(SC + 5);
    chk("spindown_done", 32'(motor_on), 32'd0);
`else
    rd(4'h8, 8'h80, "motor_off_rd");
    chk("motor_off_direct", 32'(motor_on), 32'd0);
`endif

    // position holds while stopped and resumes from where it left off
    held = trk_addr;
    cyc(3 * BC);
    chk("pos_hold", 32'(trk_addr), 32'(held));
    resume = (held == 13'(NB - 1)) ? 13'd0 : held + 13'd1;
    rd(4'h9, 8'h80, "motor_on_rd3");
    moved = 1'b0;
    for (int i = 0; i < 2 * BC + 2 && !moved; i++) begin
      if (trk_addr !== held) moved = 1'b1;
      else @(negedge clk);
    end
    chk("resume_addr", 32'(trk_addr), 32'(resume));

    // drive select
    rd(4'hB, 8'h80, "drive2_rd");
    chk("drive_sel_2", 32'(drive_sel), 32'd1);
    rd(4'hA, 8'h80, "drive1_rd");
    chk("drive_sel_1", 32'(drive_sel), 32'd0);
    rd(4'hB, 8'h80, "drive2_rd2");

    // stepper moves, no-moves and phase-off events
    for (int i = 0; i < 9; i++) begin
      rd(st_addr[i], 8'h80, "step_rd");
      chk("step_track", 32'(track), 32'(st_trk[i]));
    end

    // asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    chk("arst_motor_on", 32'(motor_on), 32'd0);
    chk("arst_track", 32'(track), 32'd0);
    chk("arst_trk_addr", 32'(trk_addr), 32'd0);
    chk("arst_d_out", 32'(d_out), 32'd0);
    chk("arst_drive_sel", 32'(drive_sel), 32'd0);
    cyc(2);
    rst_n = 1'b1;

    // saturation at both ends of travel
    rd(4'h7, 8'h00, "phase3_at_0");
    chk("sat_low", 32'(track), 32'd0);
    h = 0;
    for (int i = 0; i < 75; i++) begin
      k = (h + 1) % 4;
      rd(4'(2 * k + 1), 8'h00, "step_out_rd");
      if (h < 68) h++;
    end
    chk("sat_high", 32'(track), 32'd34);
    k = (h + 3) % 4;
    rd(4'(2 * k + 1), 8'h00, "step_back_rd");
    chk("step_back", 32'(track), 32'd33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
